// File: rtl/text_render_pkg.sv
// text_render_pkg: character codes, blank code and glyph grid size
// shared by the text line renderer and its glyph ROM.
package text_render_pkg;

  localparam logic [7:0] SPACE_CODE = 8'd32;
  localparam int GLYPH_GRID = 32;

  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_1     = 8'h31;
  localparam logic [7:0] CH_2     = 8'h32;
  localparam logic [7:0] CH_3     = 8'h33;
  localparam logic [7:0] CH_4     = 8'h34;
  localparam logic [7:0] CH_5     = 8'h35;
  localparam logic [7:0] CH_6     = 8'h36;
  localparam logic [7:0] CH_7     = 8'h37;
  localparam logic [7:0] CH_8     = 8'h38;
  localparam logic [7:0] CH_9     = 8'h39;
  localparam logic [7:0] CH_PLUS  = 8'h2b;
  localparam logic [7:0] CH_MINUS = 8'h2d;
  localparam logic [7:0] CH_STAR  = 8'h2a;
  localparam logic [7:0] CH_SLASH = 8'h2f;
  localparam logic [7:0] CH_EQ    = 8'h3d;
  localparam logic [7:0] CH_A     = 8'h41;
  localparam logic [7:0] CH_C     = 8'h43;
  localparam logic [7:0] CH_D     = 8'h44;
  localparam logic [7:0] CH_E     = 8'h45;
  localparam logic [7:0] CH_L     = 8'h4c;

  function automatic logic in_rng(
    input logic [4:0] v,
    input int lo,
    input int hi
  );
    return (int'(v) >= lo) && (int'(v) <= hi);
  endfunction

endpackage

// File: rtl/text_line_renderer_glyph_rom.sv
// glyph_rom: combinational 32x32 glyph lookup built from
// seven-segment strokes plus a few diagonal/bar primitives.
module glyph_rom
  import text_render_pkg::*;
(
  input  logic [7:0] ascii,
  input  logic [4:0] gx,
  input  logic [4:0] gy,
  output logic       pix
);

  logic sa, sb, sc, sd, se, sf, sg;
  logic vc, d1, d2, eq, dr;
  int   sum, dif;

  always_comb begin
    sa  = in_rng(gy, 2, 5) && in_rng(gx, 6, 25);
    sg  = in_rng(gy, 14, 17) && in_rng(gx, 6, 25);
    sd  = in_rng(gy, 26, 29) && in_rng(gx, 6, 25);
    sf  = in_rng(gx, 6, 9) && in_rng(gy, 2, 17);
    sb  = in_rng(gx, 22, 25) && in_rng(gy, 2, 17);
    se  = in_rng(gx, 6, 9) && in_rng(gy, 14, 29);
    sc  = in_rng(gx, 22, 25) && in_rng(gy, 14, 29);
    vc  = in_rng(gx, 14, 17);
    sum = int'(gx) + int'(gy);
    dif = int'(gx) - int'(gy);
    d1  = (dif >= -1) && (dif <= 1) && in_rng(gx, 4, 27);
    d2  = (sum >= 30) && (sum <= 32) && in_rng(gx, 4, 27);
    eq  = in_rng(gx, 6, 25) &&
          (in_rng(gy, 9, 12) || in_rng(gy, 19, 22));
    // 'D' uses a short right bar so the corners read as rounded
    dr  = in_rng(gx, 22, 25) && in_rng(gy, 6, 25);
    pix = 1'b0;
    case (ascii)
      CH_0:     pix = sa | sb | sc | sd | se | sf;
      CH_1:     pix = vc && in_rng(gy, 2, 29);
      CH_2:     pix = sa | sb | sg | se | sd;
      CH_3:     pix = sa | sb | sg | sc | sd;
      CH_4:     pix = sf | sg | sb | sc;
      CH_5:     pix = sa | sf | sg | sc | sd;
      CH_6:     pix = sa | sf | sg | se | sc | sd;
      CH_7:     pix = sa | sb | sc;
      CH_8:     pix = sa | sb | sc | sd | se | sf | sg;
      CH_9:     pix = sa | sb | sc | sd | sf | sg;
      CH_PLUS:  pix = sg | (vc && in_rng(gy, 6, 25));
      CH_MINUS: pix = sg;
      CH_STAR:  pix = d1 | d2;
      CH_SLASH: pix = d2;
      CH_EQ:    pix = eq;
      CH_A:     pix = sa | sb | sc | se | sf | sg;
      CH_C:     pix = sa | sf | se | sd;
      CH_D:     pix = sf | se | dr |
                      ((sa | sd) && in_rng(gx, 6, 21));
      CH_E:     pix = sa | sf | sg | se | sd;
      CH_L:     pix = sf | se | sd;
      default:  pix = 1'b0;
    endcase
  end

endmodule

// File: rtl/text_line_renderer.sv
// text_line_renderer: one line of character cells rendered into a
// pixel stream; blinking cursor enabled by TEXT_CURSOR_EN.
module text_line_renderer
  import text_render_pkg::*;
#(
  parameter int NUM_CELLS = 16,
  parameter int CELL_SIZE = 32,
  parameter int ORIGIN_X  = 0,
  parameter int ORIGIN_Y  = 0,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [$clog2(NUM_CELLS)-1:0] wr_addr,
  input  logic [7:0]                   wr_data,
  input  logic                         clr,
  input  logic [$clog2(NUM_CELLS)-1:0] cursor_pos,
  input  logic [9:0]                   pix_x,
  input  logic [9:0]                   pix_y,
  input  logic                         pix_valid,
  output logic                         pixel_out,
  output logic                         pixel_valid_out,
  output logic                         busy
);

  localparam int AW = $clog2(NUM_CELLS);
  localparam int CW = $clog2(CELL_SIZE);
  localparam int SH = 5 - CW;
  localparam logic [11:0] X0 = 12'(ORIGIN_X);
  localparam logic [11:0] Y0 = 12'(ORIGIN_Y);
  localparam logic [11:0] XW = 12'(NUM_CELLS * CELL_SIZE);
  localparam logic [11:0] YW = 12'(CELL_SIZE);
  localparam logic [AW:0] NC = (AW + 1)'(NUM_CELLS);
  localparam logic [AW-1:0] LAST = AW'(NUM_CELLS - 1);

  logic [7:0]    cells [NUM_CELLS];
  logic [AW-1:0] clr_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CELLS; i++) cells[i] <= SPACE_CODE;
      busy    <= 1'b0;
      clr_idx <= '0;
    end else if (busy) begin
      cells[clr_idx] <= SPACE_CODE;
      clr_idx        <= clr_idx + 1'b1;
      if (clr_idx == LAST) busy <= 1'b0;
    end else begin
      if (wr_en && ({1'b0, wr_addr} < NC)) cells[wr_addr] <= wr_data;
      if (clr) begin
        busy    <= 1'b1;
        clr_idx <= '0;
      end
    end
  end

  logic [11:0]   dx, dy;
  logic          hit;
  logic [AW-1:0] cell_c;
  logic [7:0]    char_c;

  always_comb begin
    dx     = {2'b00, pix_x} - X0;
    dy     = {2'b00, pix_y} - Y0;
    hit    = ({2'b00, pix_x} >= X0) && (dx < XW) &&
             ({2'b00, pix_y} >= Y0) && (dy < YW);
    cell_c = AW'(dx >> CW);
    char_c = hit ? cells[cell_c] : SPACE_CODE;
  end

  // stage 1: the cell read sees the pre-write value on a same-edge write
  logic          s1_valid, s1_hit;
  logic [AW-1:0] s1_cell;
  logic [CW-1:0] s1_lx, s1_ly;
  logic [7:0]    s1_char;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_hit   <= 1'b0;
      s1_cell  <= '0;
      s1_lx    <= '0;
      s1_ly    <= '0;
      s1_char  <= '0;
    end else begin
      s1_valid <= pix_valid;
      s1_hit   <= hit;
      s1_cell  <= cell_c;
      s1_lx    <= dx[CW-1:0];
      s1_ly    <= dy[CW-1:0];
      s1_char  <= char_c;
    end
  end

  logic [4:0] gx, gy;
  logic       gbit, inv;

  assign gx = 5'(s1_lx) << SH;
  assign gy = 5'(s1_ly) << SH;

  glyph_rom u_rom (
    .ascii (s1_char),
    .gx    (gx),
    .gy    (gy),
    .pix   (gbit)
  );

`ifdef TEXT_CURSOR_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  assign inv = blink_phase && s1_hit && (s1_cell == cursor_pos);
`else
  logic unused_cfg;
  assign unused_cfg = (^cursor_pos) ^ (BLINK_DIV == 0);
  assign inv = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_out       <= 1'b0;
      pixel_valid_out <= 1'b0;
    end else begin
      pixel_out       <= s1_valid && s1_hit && (gbit ^ inv);
      pixel_valid_out <= s1_valid;
    end
  end

endmodule
